ttt_win_checker: RTL and testbench
==================================

# ttt_win_checker

Sequential win/draw detector for the tic-tac-toe game. It sits directly upstream of the game FSM and its `matrix_complete`/finish decision. It snapshots the two per-player 9-cell boards, scans the 8 winning lines one per clock, and reports winner, winning line and draw with a start/done handshake. Its outputs drive the FSM transition to the GAME_OVER state and the VGA line highlight.

## Interface
Parameters:
- `NUM_LINES`, default 8, number of winning lines scanned (fixed by the board; not overridable in practice).

Ports:
- `clk` in 1: system clock (50 MHz board clock); sole clock.
- `rst` in 1: reset, synchronous, active-high.
- `board_p1` in 9: player 1 marks; bit i = cell i, i = row*3+col, row/col 0..2.
- `board_p2` in 9: player 2 marks, same encoding.
- `start` in 1: request a scan; accepted only in IDLE.
- `busy` out 1: high while in SCAN.
- `done` out 1: one-cycle pulse when results are final.
- `winner` out 2: 00 none, 01 player 1, 10 player 2; 11 never produced.
- `win_line` out 3: index of the winning line; 0 when `winner`=00.
- `draw` out 1: no winner and all 9 cells occupied.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE with `start`=1:
  - Register `snap_p1`/`snap_p2` from the inputs.
  - Clear `winner`, `win_line` and `draw`.
  - Set `idx`=0 and go to SCAN.
- SCAN evaluates line `idx` against the snapshot only. Input changes during a scan are ignored.
- Line order:
  - 0–2: rows {0,1,2}, {3,4,5}, {6,7,8}.
  - 3–5: columns {0,3,6}, {1,4,7}, {2,5,8}.
  - 6: diagonal {0,4,8}.
  - 7: diagonal {2,4,6}.
- Line match: `(snap & mask) == mask`. Player 1 is tested before player 2 on the same line.
- First match ends the scan early: register `winner` and `win_line`=`idx`, then go to DONE.
- `idx`=7 with no match: `draw` = `(snap_p1|snap_p2)==9'h1FF`, `winner`=00, then go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE. `start` in DONE is ignored.
- Results hold their values until the next accepted `start`.
- Illegal boards are scanned as-is with no error reporting:
  - A cell set in both boards.
  - Both players owning a line: the lowest-index line wins, with player 1 priority within a line.
- `start` in SCAN or DONE is dropped, not queued.

## Timing
- Reset: state IDLE, `idx`=0, snapshots 0, `busy`=0, `done`=0, `winner`=00, `win_line`=0, `draw`=0.
- Reset mid-scan aborts the scan immediately. `done` is not produced.
- `start` sampled high at edge of cycle 0:
  - Line L is evaluated in cycle L+1.
  - With a match on line L, `done` is high in cycle L+2. Minimum latency is 2 cycles, for line 0.
  - With no match, `done` is high in cycle 9.
- `busy` is high in cycles 1 .. (done cycle − 1).
- `winner`, `win_line` and `draw` are registered and valid in the `done` cycle and after.
- Back-to-back: the earliest next `start` accepted is the cycle after `done`.

## Configuration
- `TTT_AUTO_SCAN_EN` defined:
  - The block keeps the last-scanned snapshot.
  - In IDLE, any difference between the current inputs and that snapshot starts a scan exactly as `start` would, one cycle later.
  - `start` still works.
- Undefined: scans start only on `start`, and there is no change-detection logic.

## Structure
- Package `ttt_pkg`:
  - `winner_t` enum (NONE, P1, P2).
  - `chk_state_t` enum (IDLE, SCAN, DONE).
  - `NUM_LINES`=8.
  - `LINE_MASKS[8]` of 9-bit constants, in the order above.
- No sub-module. The mask lookup is a package constant indexed by `idx`, and the FSM plus datapath live in one module.

## Test plan
- P1 = 9'b000000111 (row 0), P2 = 0, pulse `start` → `done` in cycle 2, `winner`=01, `win_line`=0, `draw`=0.
- P2 = 9'b001010100 (cells 2,4,6), P1 = 9'b000000011 → `done` in cycle 9, `winner`=10, `win_line`=7.
- Full board without a win: P1=9'b010011101, P2=9'b101100010 → `done` in cycle 9, `winner`=00, `draw`=1.
- Pulse `start` in cycle 3 of a scan and change the inputs mid-scan → `start` ignored, result reflects the original snapshot, single `done`.
- Assert `rst` in cycle 4 of a scan → next cycle all outputs are 0 and `done` never pulses. A following `start` completes normally.
- With `TTT_AUTO_SCAN_EN`: set P1 bit 4 with no `start` → scan starts unprompted and `done` pulses with `winner`=00. Holding the inputs steady triggers no further scans.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe win checker.
// LINE_MASKS order: rows 0-2, columns 3-5, main diagonal 6, anti-diagonal 7.
package ttt_pkg;

   localparam int NUM_LINES = 8;

   typedef enum logic [1:0] {
      NONE = 2'b00,
      P1   = 2'b01,
      P2   = 2'b10
   } winner_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SCAN = 2'b01,
      DONE = 2'b10
   } chk_state_t;

   // Bit i is cell i, where i = row*3 + col.
   localparam logic [8:0] LINE_MASKS [NUM_LINES] = '{
      9'b000000111,
      9'b000111000,
      9'b111000000,
      9'b001001001,
      9'b010010010,
      9'b100100100,
      9'b100010001,
      9'b001010100
   };

endpackage

// File: rtl/ttt_win_checker.sv
// Sequential win/draw detector: snapshots both boards, then tests one winning line per clock.
// Optional macro TTT_AUTO_SCAN_EN: any board change seen while IDLE starts a scan like i_start.
module ttt_win_checker #(
   parameter int NUM_LINES = 8
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [8:0] i_board_p1,
   input  logic [8:0] i_board_p2,
   input  logic       i_start,
   output logic       o_busy,
   output logic       o_done,
   output logic [1:0] o_winner,
   output logic [2:0] o_win_line,
   output logic       o_draw
);

   import ttt_pkg::*;

   localparam logic [2:0] LAST_IDX = 3'(NUM_LINES - 1);

   chk_state_t r_state;
   chk_state_t w_next_state;
   logic [8:0] r_snap_p1;
   logic [8:0] r_snap_p2;
   logic [2:0] r_idx;
   winner_t    r_winner;
   logic [2:0] r_win_line;
   logic       r_draw;

   logic [8:0] w_mask;
   logic       w_p1_hit;
   logic       w_p2_hit;
   logic       w_start_req;

`ifdef TTT_AUTO_SCAN_EN
   // The snapshot doubles as the "last scanned" copy for change detection.
   assign w_start_req = i_start | (i_board_p1 != r_snap_p1) | (i_board_p2 != r_snap_p2);
`else
   assign w_start_req = i_start;
`endif

   assign w_mask   = LINE_MASKS[r_idx];
   assign w_p1_hit = ((r_snap_p1 & w_mask) == w_mask);
   assign w_p2_hit = ((r_snap_p2 & w_mask) == w_mask);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_start_req) begin
               w_next_state = SCAN;
            end
         end
         SCAN: begin
            if (w_p1_hit || w_p2_hit || (r_idx == LAST_IDX)) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_snap_p1  <= '0;
         r_snap_p2  <= '0;
         r_idx      <= '0;
         r_winner   <= NONE;
         r_win_line <= '0;
         r_draw     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start_req) begin
                  r_snap_p1  <= i_board_p1;
                  r_snap_p2  <= i_board_p2;
                  r_idx      <= '0;
                  r_winner   <= NONE;
                  r_win_line <= '0;
                  r_draw     <= 1'b0;
               end
            end
            SCAN: begin
               // Player 1 wins ties on the same line; lowest line index wins overall.
               if (w_p1_hit) begin
                  r_winner   <= P1;
                  r_win_line <= r_idx;
               end else if (w_p2_hit) begin
                  r_winner   <= P2;
                  r_win_line <= r_idx;
               end else if (r_idx == LAST_IDX) begin
                  r_draw <= ((r_snap_p1 | r_snap_p2) == 9'h1FF);
               end else begin
                  r_idx <= r_idx + 3'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_busy     = (r_state == SCAN);
   assign o_done     = (r_state == DONE);
   assign o_winner   = r_winner;
   assign o_win_line = r_win_line;
   assign o_draw     = r_draw;

endmodule

// File: tb/tb_ttt_win_checker.sv
// Self-checking bench for ttt_win_checker: vector table, corner sequences and random boards vs a line-rule model.
// Also exercises the TTT_AUTO_SCAN_EN behaviour when that macro is defined.
module tb_ttt_win_checker;

   logic       clk;
   logic       rst;
   logic [8:0] boardP1;
   logic [8:0] boardP2;
   logic       start;
   logic       busy;
   logic       done;
   logic [1:0] winner;
   logic [2:0] winLine;
   logic       draw;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [8:0] p1;
      logic [8:0] p2;
      logic [1:0] win;
      logic [2:0] line;
      logic       drw;
      int         doneCyc;
   } vec_t;

   vec_t vecs [9];

   ttt_win_checker dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_board_p1 (boardP1),
      .i_board_p2 (boardP2),
      .i_start    (start),
      .o_busy     (busy),
      .o_done     (done),
      .o_winner   (winner),
      .o_win_line (winLine),
      .o_draw     (draw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Line l as a set of cells: rows, then columns, then the two diagonals.
   function automatic logic [8:0] lineMask(input int l);
      logic [8:0] m;
      m = '0;
      for (int k = 0; k < 3; k++) begin
         if (l < 3)       m[l*3 + k] = 1'b1;
         else if (l < 6)  m[(l-3) + 3*k] = 1'b1;
         else if (l == 6) m[4*k] = 1'b1;
         else             m[2 + 2*k] = 1'b1;
      end
      return m;
   endfunction

   function automatic void refModel(input logic [8:0] p1, input logic [8:0] p2,
                                    output logic [1:0] w, output logic [2:0] l,
                                    output logic d, output int cyc);
      w = 2'b00; l = 3'd0; d = 1'b0; cyc = 9;
      for (int i = 0; i < 8; i++) begin
         logic [8:0] m;
         m = lineMask(i);
         if ((p1 & m) == m) begin
            w = 2'b01; l = 3'(i); cyc = i + 2; return;
         end
         if ((p2 & m) == m) begin
            w = 2'b10; l = 3'(i); cyc = i + 2; return;
         end
      end
      d = &(p1 | p2);
   endfunction

   // Launches a scan and returns the cycle (relative to the start edge) in which done rose.
   task automatic applyStimulus(input logic [8:0] p1, input logic [8:0] p2, input int disturbCyc,
                                output int doneCyc);
      int cyc;
      doneCyc = -1;
      @(negedge clk);
      boardP1 = p1; boardP2 = p2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (cyc <= 20) begin
         if (done) begin
            doneCyc = cyc;
            checkOutput("busy_in_done_cycle", int'(busy), 0);
            break;
         end
         checkOutput("busy_during_scan", int'(busy), 1);
         if (cyc == disturbCyc) begin
            start = 1'b1; boardP1 = ~p1; boardP2 = ~p2;
         end
         @(negedge clk);
         if (cyc == disturbCyc) begin
            start = 1'b0; boardP1 = p1; boardP2 = p2;
         end
         cyc++;
      end
   endtask

   task automatic runVector(input string tag, input logic [8:0] p1, input logic [8:0] p2, input int disturbCyc);
      logic [1:0] expW;
      logic [2:0] expL;
      logic       expD;
      int         expCyc;
      int         gotCyc;
      refModel(p1, p2, expW, expL, expD, expCyc);
      applyStimulus(p1, p2, disturbCyc, gotCyc);
      checkOutput({tag, "_done_cycle"}, gotCyc, expCyc);
      checkOutput({tag, "_winner"}, int'(winner), int'(expW));
      checkOutput({tag, "_win_line"}, int'(winLine), int'(expL));
      checkOutput({tag, "_draw"}, int'(draw), int'(expD));
      @(negedge clk);
      checkOutput({tag, "_done_single"}, int'(done), 0);
      checkOutput({tag, "_winner_held"}, int'(winner), int'(expW));
   endtask

   task automatic countDone(input int nCycles, output int pulses);
      pulses = 0;
      for (int i = 0; i < nCycles; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
   endtask

   initial begin
      int gotCyc;
      int pulses;
      logic [8:0] rp1;
      logic [8:0] rp2;

      vecs[0] = '{9'h007, 9'h000, 2'b01, 3'd0, 1'b0, 2};
      vecs[1] = '{9'h003, 9'h054, 2'b10, 3'd7, 1'b0, 9};
      vecs[2] = '{9'h09D, 9'h162, 2'b00, 3'd0, 1'b1, 9};
      vecs[3] = '{9'h000, 9'h000, 2'b00, 3'd0, 1'b0, 9};
      vecs[4] = '{9'h011, 9'h124, 2'b10, 3'd5, 1'b0, 7};
      vecs[5] = '{9'h1C0, 9'h007, 2'b10, 3'd0, 1'b0, 2};
      vecs[6] = '{9'h1FF, 9'h1FF, 2'b01, 3'd0, 1'b0, 2};
      vecs[7] = '{9'h111, 9'h000, 2'b01, 3'd6, 1'b0, 8};
      vecs[8] = '{9'h092, 9'h009, 2'b01, 3'd4, 1'b0, 6};

      rst = 1'b1; start = 1'b0; boardP1 = '0; boardP2 = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      checkOutput("reset_winner", int'(winner), 0);
      checkOutput("reset_win_line", int'(winLine), 0);
      checkOutput("reset_draw", int'(draw), 0);
      rst = 1'b0;

      for (int v = 0; v < 9; v++) begin
         applyStimulus(vecs[v].p1, vecs[v].p2, 0, gotCyc);
         checkOutput($sformatf("vec%0d_done_cycle", v), gotCyc, vecs[v].doneCyc);
         checkOutput($sformatf("vec%0d_winner", v), int'(winner), int'(vecs[v].win));
         checkOutput($sformatf("vec%0d_win_line", v), int'(winLine), int'(vecs[v].line));
         checkOutput($sformatf("vec%0d_draw", v), int'(draw), int'(vecs[v].drw));
         @(negedge clk);
         checkOutput($sformatf("vec%0d_done_single", v), int'(done), 0);
      end

      // start pulse and board change in cycle 3 must not disturb the snapshot scan.
      runVector("midscan", 9'h000, 9'h054, 3);
      countDone(12, pulses);
      checkOutput("midscan_no_extra_done", pulses, 0);

      // Reset in cycle 4 aborts the scan.
      @(negedge clk);
      boardP1 = 9'h000; boardP2 = 9'h054; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1; boardP1 = '0; boardP2 = '0;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_done", int'(done), 0);
      checkOutput("abort_winner", int'(winner), 0);
      checkOutput("abort_win_line", int'(winLine), 0);
      checkOutput("abort_draw", int'(draw), 0);
      countDone(12, pulses);
      checkOutput("abort_no_done", pulses, 0);
      runVector("after_abort", 9'h038, 9'h000, 0);

      for (int n = 0; n < 40; n++) begin
         rp1 = '0; rp2 = '0;
         if (n % 4 == 3) begin
            rp1 = 9'($urandom_range(0, 511));
            rp2 = 9'($urandom_range(0, 511));
         end else begin
            for (int c = 0; c < 9; c++) begin
               case ($urandom_range(0, 2))
                  1: rp1[c] = 1'b1;
                  2: rp2[c] = 1'b1;
                  default: ;
               endcase
            end
         end
         runVector($sformatf("rand%0d", n), rp1, rp2, 0);
      end

`ifdef TTT_AUTO_SCAN_EN
      runVector("auto_base", 9'h000, 9'h000, 0);
      @(negedge clk);
      boardP1 = 9'h010;
      gotCyc = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done) begin
            gotCyc = i;
            break;
         end
      end
      checkOutput("auto_done_cycle", gotCyc, 9);
      checkOutput("auto_winner", int'(winner), 0);
      checkOutput("auto_draw", int'(draw), 0);
      countDone(20, pulses);
      checkOutput("auto_steady_no_rescan", pulses, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
